// File: rtl/hsid_multiplier_if.sv
// Operand/result bundle between the hsid datapath and the iterative multiplier.
// The master drives the operands and control; the slave (the multiplier) drives status and result.
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif

interface hsid_multiplier_if #(
    parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
    parameter int K                 = 32
);
    logic                         clear;
    logic                         start;
    logic [K-1:0]                 multiplicand;
    logic [K-1:0]                 multiplier;
    logic                         of_in;
    logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_in;
    logic                         idle;
    logic                         ready;
    logic                         done;
    logic [2*K-1:0]               product;
    logic                         overflow;
    logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_out;

    modport master (
        output clear, start, multiplicand, multiplier, of_in, hsp_ref_in,
        input  idle, ready, done, product, overflow, hsp_ref_out
    );

    modport slave (
        input  clear, start, multiplicand, multiplier, of_in, hsp_ref_in,
        output idle, ready, done, product, overflow, hsp_ref_out
    );
endinterface

// File: rtl/hsid_multiplier.sv
// Iterative radix-2 shift-add KxK unsigned multiplier with tag/overflow passthrough.
// Latency K+1 cycles start-to-done (data dependent when HSID_MUL_EARLY_EXIT_EN is defined).
// No backpressure: start accepted only while ready; done is a one-cycle pulse, result holds.
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif

module hsid_multiplier #(
    parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
    parameter int K                 = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hsid_multiplier_if.slave    mul
);
    localparam int DK = 2 * K;
    localparam int SW = (K > 2) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2,
        S_CLEAR   = 2'd3
    } state_t;

    state_t                       state;
    logic [DK-1:0]                mcand_reg;
    logic [K-1:0]                 mplier_reg;
    logic [DK-1:0]                acc;
    logic [SW-1:0]                step;
    logic [DK-1:0]                product_q;
    logic                         overflow_q;
    logic [HSP_LIBRARY_WIDTH-1:0] tag_q;
    logic                         idle_q;
    logic                         ready_q;
    logic                         done_q;

    logic [DK-1:0]                acc_nxt;
    logic [K-1:0]                 mplier_shift;
    logic                         last_step;

    always_comb begin
        acc_nxt      = mplier_reg[0] ? (acc + mcand_reg) : acc;
        mplier_shift = mplier_reg >> 1;
`ifdef HSID_MUL_EARLY_EXIT_EN
        // No set bits remain, so every further step would add nothing.
        last_step    = (step == '0) || (mplier_shift == '0);
`else
        last_step    = (step == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc        <= '0;
            step       <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            tag_q      <= '0;
            idle_q     <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mul.clear) begin
                        mcand_reg  <= '0;
                        mplier_reg <= '0;
                        acc        <= '0;
                        step       <= '0;
                        product_q  <= '0;
                        overflow_q <= 1'b0;
                        tag_q      <= '0;
                    end else if (mul.start) begin
                        state      <= S_COMPUTE;
                        mcand_reg  <= {{K{1'b0}}, mul.multiplicand};
                        mplier_reg <= mul.multiplier;
                        acc        <= '0;
                        step       <= SW'(K - 1);
                        overflow_q <= mul.of_in;
                        tag_q      <= mul.hsp_ref_in;
                        idle_q     <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    acc        <= acc_nxt;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_shift;
                    step       <= step - SW'(1);
                    if (mul.clear) begin
                        state <= S_CLEAR;
                    end else if (last_step) begin
                        state     <= S_DONE;
                        product_q <= acc_nxt;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    ready_q <= 1'b1;
                end
                S_CLEAR: begin
                    state      <= S_IDLE;
                    mcand_reg  <= '0;
                    mplier_reg <= '0;
                    acc        <= '0;
                    step       <= '0;
                    product_q  <= '0;
                    overflow_q <= 1'b0;
                    tag_q      <= '0;
                    idle_q     <= 1'b1;
                    ready_q    <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    idle_q  <= 1'b1;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mul.idle        = idle_q;
    assign mul.ready       = ready_q;
    assign mul.done        = done_q;
    assign mul.product     = product_q;
    assign mul.overflow    = overflow_q;
    assign mul.hsp_ref_out = tag_q;
endmodule
